// File: rtl/inst_loader.sv
// Instruction-memory loader: streams D_W-bit words over valid/ready into sequential write addresses from 0.
// Optional trailing XOR checksum word when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader #(
    parameter int A_W = 11,
    parameter int D_W = 9
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           Start,
    input  logic [A_W:0]   LoadLen,
    input  logic [D_W-1:0] InData,
    input  logic           InValid,
    output logic           InReady,
    output logic           WrEn,
    output logic [A_W-1:0] WrAddr,
    output logic [D_W-1:0] WrData,
    output logic           Busy,
    output logic           Done,
    output logic           Error,
    output logic [1:0]     dbg_state
);

    // Handshake: a word transfers on a rising edge where InValid and InReady are both 1.
    // InReady is decoded purely from state, so it never depends on InValid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [A_W:0] MAX_LEN = {1'b1, {A_W{1'b0}}};

    state_t         state, next_state;
    logic [A_W-1:0] ptr;
    logic [A_W:0]   remaining;
    logic [A_W:0]   len_clamped;
    logic           xfer;
    logic           last_xfer;
    state_t         after_load;
    state_t         empty_next;

`ifdef INST_LOADER_CHECKSUM_EN
    assign InReady    = (state == LOAD) || (state == CHECK);
    assign after_load = CHECK;
    assign empty_next = CHECK;
`else
    assign InReady    = (state == LOAD);
    assign after_load = DONE;
    assign empty_next = DONE;
`endif

    assign Busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        next_state  = state;
        len_clamped = (LoadLen > MAX_LEN) ? MAX_LEN : LoadLen;
        xfer        = InValid && InReady;
        last_xfer   = xfer && (state == LOAD) && (remaining == (A_W+1)'(1));
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = (len_clamped == '0) ? empty_next : LOAD;
                end
            end
            LOAD: begin
                if (last_xfer) begin
                    next_state = after_load;
                end
            end
            CHECK: begin
                if (xfer) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= '0;
            Done      <= 1'b0;
        end else begin
            state <= next_state;
            WrEn  <= 1'b0;
            Done  <= (state == DONE);
            if ((state == IDLE) && Start) begin
                ptr       <= '0;
                remaining <= len_clamped;
            end
            // The pointer may wrap to 0 after a full-depth load; it is never used afterwards.
            if ((state == LOAD) && xfer) begin
                WrEn      <= 1'b1;
                WrAddr    <= ptr;
                WrData    <= InData;
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic [D_W-1:0] csum;
    logic           err_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state == IDLE) && Start) begin
                csum  <= '0;
                err_q <= 1'b0;
            end
            if ((state == LOAD) && xfer) begin
                csum <= csum ^ InData;
            end
            // The checksum word itself is compared but never written.
            if ((state == CHECK) && xfer && (InData != csum)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Error = err_q;
`else
    assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for inst_loader: loads are modelled as lists of words, the monitor checks
// every write strobe and Done pulse against the expected event queue.
module tb_inst_loader;

    localparam int A_W = 11;
    localparam int D_W = 9;
    localparam int EW  = 1 + A_W + D_W;
    localparam int DEPTH = 1 << A_W;

    logic           CLK = 1'b0;
    logic           Reset;
    logic           Start;
    logic [A_W:0]   LoadLen;
    logic [D_W-1:0] InData;
    logic           InValid;
    logic           InReady;
    logic           WrEn;
    logic [A_W-1:0] WrAddr;
    logic [D_W-1:0] WrData;
    logic           Busy;
    logic           Done;
    logic           Error;
    logic [1:0]     dbg_state;

    inst_loader #(.A_W(A_W), .D_W(D_W)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .LoadLen(LoadLen),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Busy(Busy), .Done(Done), .Error(Error), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Entry: {is_done, addr, data} for writes; done markers carry the expected previous-cycle WrEn in bit 0.
    logic [EW-1:0]  exp_q[$];
    logic [D_W-1:0] dir_w[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 0;
    logic prev_wren = 1'b0;
    logic exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            logic [EW-1:0] e;
            if (WrEn) begin
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_addr_data", 32'({1'b0, WrAddr, WrData}), 32'(e));
                end
            end
            if (Done) begin
                check("done_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("done_marker", 32'(e[EW-1]), 1);
                    check("done_after_last_wr", 32'(prev_wren), 32'(e[0]));
                    check("busy_at_done", 32'(Busy), 0);
                end
            end
            prev_wren = WrEn;
        end
    end

    // ---------------- driver tasks (entered and left #1 after a rising edge) ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load(input logic [A_W:0] len);
        Start   = 1'b1;
        LoadLen = len;
        tick();
        Start   = 1'b0;
        LoadLen = (A_W+1)'($urandom);
    endtask

    task automatic send_word(input logic [D_W-1:0] d, input int bub_pct, input bit poke_start);
        bit sent = 0;
        int guard = 0;
        while (!sent && guard < 200) begin
            guard++;
            if (int'($urandom_range(0, 99)) < bub_pct) begin
                InValid = 1'b0;
                InData  = D_W'($urandom);
            end else begin
                InValid = 1'b1;
                InData  = d;
            end
            Start   = poke_start && ($urandom_range(0, 1) == 1);
            LoadLen = (A_W+1)'($urandom);
            sent    = InValid && InReady;
            tick();
        end
        InValid = 1'b0;
        Start   = 1'b0;
        if (!sent) check("send_timeout", 32'(sent), 1);
    endtask

    // Reference model: a load of n words writes word i at address i; optional checksum is the XOR of all words.
    task automatic run_load(input logic [A_W:0] len, input int bub_pct, input bit poke_start, input bit bad_sum);
        int n;
        logic [D_W-1:0] words[$];
        logic [D_W-1:0] x;
        logic [D_W-1:0] w;
        logic [EW-1:0]  m;
        int g;
        n = (int'(len) > DEPTH) ? DEPTH : int'(len);
        x = '0;
        for (int i = 0; i < n; i++) begin
            w = (i < dir_w.size()) ? dir_w[i] : D_W'($urandom);
            words.push_back(w);
            x = x ^ w;
            exp_q.push_back({1'b0, A_W'(i), w});
        end
        m = '0;
        m[EW-1] = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
        m[0] = 1'b0;
        exp_err = bad_sum;
`else
        m[0] = (n > 0);
        exp_err = 1'b0;
`endif
        exp_q.push_back(m);
        start_load(len);
        check("error_cleared_on_start", 32'(Error), 0);
`ifndef INST_LOADER_CHECKSUM_EN
        if (n == 0) begin
            check("len0_done_early", 32'(Done), 0);
            tick();
            check("len0_done", 32'(Done), 1);
        end
`endif
        foreach (words[i]) send_word(words[i], bub_pct, poke_start);
`ifdef INST_LOADER_CHECKSUM_EN
        send_word(bad_sum ? (x ^ D_W'(1)) : x, bub_pct, 1'b0);
`endif
        g = 0;
        while (!Done && g < 10) begin
            tick();
            g++;
        end
        check("done_seen", 32'(Done), 1);
        tick();
        check("done_one_cycle", 32'(Done), 0);
        check("busy_idle", 32'(Busy), 0);
        check("error_state", 32'(Error), 32'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; Start = 1'b0; LoadLen = '0; InData = '0; InValid = 1'b0;
        tick();
        tick();
        check("rst_wren", 32'(WrEn), 0);
        check("rst_wraddr", 32'(WrAddr), 0);
        check("rst_wrdata", 32'(WrData), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_inready", 32'(InReady), 0);
        check("rst_error", 32'(Error), 0);
        mon_en = 1;
        Reset = 1'b0;
        tick();

        dir_w = '{9'h001, 9'h049, 9'h1FF};
        run_load(3, 0, 0, 0);
        dir_w.delete();
        run_load(4, 50, 0, 0);
        run_load(0, 0, 0, 0);
        run_load(6, 20, 1, 0);

        // Reset in the middle of a 5-word load after two transfers.
        start_load(5);
        for (int i = 0; i < 2; i++) begin
            logic [D_W-1:0] w;
            w = D_W'($urandom);
            exp_q.push_back({1'b0, A_W'(i), w});
            send_word(w, 0, 0);
        end
        Reset = 1'b1; InValid = 1'b1; InData = D_W'($urandom); Start = 1'b1;
        tick();
        check("abort_wren", 32'(WrEn), 0);
        check("abort_inready", 32'(InReady), 0);
        check("abort_busy", 32'(Busy), 0);
        check("abort_done", 32'(Done), 0);
        tick();
        Reset = 1'b0; InValid = 1'b0; Start = 1'b0;
        tick();
        tick();
        check("abort_no_more_events", exp_q.size(), 0);
        exp_err = 1'b0;

        dir_w = '{9'h0F0, 9'h00F};
        run_load(2, 0, 0, 0);
        run_load(2, 0, 0, 1);
        tick();
        tick();
        check("error_held", 32'(Error), 32'(exp_err));
        dir_w.delete();

        for (int k = 0; k < 10; k++) begin
            run_load((A_W+1)'($urandom_range(1, 40)), int'($urandom_range(0, 60)), 1, $urandom_range(0, 1) == 1);
        end

        run_load((A_W+1)'(DEPTH), 0, 0, 0);
        run_load({(A_W+1){1'b1}}, 10, 0, 0);

        for (int i = 0; i < 5; i++) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
